// File: rtl/alu_result_queue.sv
// Collects one ALU function-unit result per cycle, selects it by opcode, attaches
// status flags, and buffers the entries in a first-word-fall-through FIFO drained by valid/ready.
module alu_result_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 opcode,
  input  logic [WIDTH-1:0]           and_res,
  input  logic [WIDTH-1:0]           or_res,
  input  logic [WIDTH-1:0]           not_res,
  input  logic [WIDTH-1:0]           add_res,
  input  logic                       add_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic                       out_carry,
  output logic                       out_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_NOT = 4'd2,
    OP_ADD = 4'd3
  } op_e;

  typedef struct packed {
    logic             err;
    logic             carry;
    logic             neg;
    logic             zero;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      illegal_cnt_q, illegal_cnt_d;

  entry_t          new_entry;
  entry_t          head;
  logic            push, pop;

  // Handshake decode uses registered state only, so no input reaches in_ready or out_valid.
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every variable gets a default at the top of an always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    new_entry = '0;
    case (opcode)
      OP_AND:  new_entry.data = and_res;
      OP_OR:   new_entry.data = or_res;
      OP_NOT:  new_entry.data = not_res;
      OP_ADD:  new_entry.data = add_res;
      default: new_entry.err  = 1'b1;
    endcase
    new_entry.carry = (opcode == OP_ADD) && add_cout;
    new_entry.zero  = (new_entry.data == '0);
    new_entry.neg   = new_entry.data[WIDTH-1];
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    illegal_cnt_d = illegal_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && new_entry.err && (illegal_cnt_q != 8'hFF))
      illegal_cnt_d = illegal_cnt_q + 8'd1;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      illegal_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; stale contents are never visible
  // because the head outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= new_entry;
  end

  always_comb begin
    head = '0;
    if (out_valid) head = mem_q[rd_ptr_q];
  end

  assign out_data    = head.data;
  assign out_zero    = head.zero;
  assign out_neg     = head.neg;
  assign out_carry   = head.carry;
  assign out_err     = head.err;
  assign count       = count_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_alu_result_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        opcode = '0;
  logic [WIDTH-1:0]  and_res = '0, or_res = '0, not_res = '0, add_res = '0;
  logic              add_cout = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_data;
  logic              out_zero, out_neg, out_carry, out_err;
  logic [$clog2(DEPTH):0] count;
  logic [7:0]        illegal_cnt;

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .and_res(and_res), .or_res(or_res), .not_res(not_res), .add_res(add_res),
    .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_neg(out_neg), .out_carry(out_carry), .out_err(out_err),
    .count(count), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entries are {err, carry, neg, zero, data}.
  logic [WIDTH+3:0] exp_q[$];
  int               exp_ill = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH+3:0] ref_entry();
    logic [WIDTH-1:0] res;
    logic err, carry;
    err   = 1'b0;
    carry = 1'b0;
    res   = '0;
    if      (opcode == 4'd0) res = and_res;
    else if (opcode == 4'd1) res = or_res;
    else if (opcode == 4'd2) res = not_res;
    else if (opcode == 4'd3) begin res = add_res; carry = add_cout; end
    else err = 1'b1;
    return {err, carry, res[WIDTH-1], (res == 0), res};
  endfunction

  task automatic check_outputs();
    logic [WIDTH+3:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("in_ready",    32'(in_ready),  32'(exp_q.size() != DEPTH));
    check("out_valid",   32'(out_valid), 32'(exp_q.size() != 0));
    check("out_data",    32'(out_data),  32'(head[WIDTH-1:0]));
    check("flags",       32'({out_err, out_carry, out_neg, out_zero}), 32'(head[WIDTH+3:WIDTH]));
    check("count",       32'(count),     32'(exp_q.size()));
    check("illegal_cnt", 32'(illegal_cnt), 32'(exp_ill));
  endtask

  // Called between edges with inputs already driven; advances one clock and the model.
  task automatic cycle();
    logic do_push, do_pop;
    logic [WIDTH+3:0] ent;
    check_outputs();
    do_push = in_valid && (exp_q.size() != DEPTH);
    do_pop  = out_ready && (exp_q.size() != 0);
    ent     = ref_entry();
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      exp_q.push_back(ent);
      if (ent[WIDTH+3] && exp_ill < 255) exp_ill++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_q.delete();
    exp_ill = 0;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [WIDTH-1:0] v, input logic co);
    in_valid = 1'b1;
    opcode   = op;
    and_res  = (op == 4'd0) ? v : 16'h1234;
    or_res   = (op == 4'd1) ? v : 16'h5678;
    not_res  = (op == 4'd2) ? v : 16'h9ABC;
    add_res  = (op == 4'd3) ? v : 16'hDEF0;
    add_cout = co;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check_outputs();

    // Single AND push becomes visible one edge later.
    drive(4'd0, 16'h00F0, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("tp1_data", 32'(out_data), 32'h00F0);
    check("tp1_count", 32'(count), 32'd1);
    cycle();

    // NOT then ADD, drained in order with flags.
    do_reset();
    drive(4'd2, 16'hFFFF, 1'b0); cycle();
    drive(4'd3, 16'h0000, 1'b1); cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("tp2_pop1_data",  32'(out_data), 32'hFFFF);
    check("tp2_pop1_flags", 32'({out_err, out_carry, out_neg, out_zero}), 32'b0010);
    cycle();
    check("tp2_pop2_data",  32'(out_data), 32'h0000);
    check("tp2_pop2_flags", 32'({out_err, out_carry, out_neg, out_zero}), 32'b0101);
    cycle();
    cycle();

    // Fill past capacity, then stream through pointer wrap.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'd1, WIDTH'(16'h0100 + i), 1'b0);
      cycle();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(4'd1, WIDTH'(16'h0200 + i), 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Illegal opcodes and counter saturation.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd7, 16'h4444, 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    check("ill_data",  32'(out_data), 32'd0);
    check("ill_flags", 32'({out_err, out_carry, out_neg, out_zero}), 32'b1001);
    check("ill_cnt3",  32'(illegal_cnt), 32'd3);
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(4, 15)), 16'($urandom), 1'($urandom));
      cycle();
    end
    in_valid = 1'b0;
    check("ill_sat", 32'(illegal_cnt), 32'd255);
    for (int i = 0; i < 4; i++) cycle();

    // Asynchronous reset between edges with three entries queued.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd3, WIDTH'(16'h8000 + i), 1'b1);
      cycle();
    end
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_count",     32'(count),     32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_out_data",  32'(out_data),  32'd0);
    @(negedge clk);
    exp_q.delete();
    exp_ill = 0;
    rst_n = 1'b1;
    drive(4'd0, 16'hA5A5, 1'b0);
    cycle();
    in_valid = 1'b0;
    check("post_rst_data", 32'(out_data), 32'hA5A5);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      opcode    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      and_res   = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      or_res    = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      not_res   = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      add_res   = ($urandom_range(0, 5) == 0) ? '0 : 16'($urandom);
      add_cout  = 1'($urandom);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
